// File: rtl/otter_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : otter_mem_arbiter
// Brief    : Fixed-priority arbiter (debug > data > fetch, with fetch
//            anti-starvation) onto one synchronous single-port memory,
//            plus a halt/drain handshake for the CPU-side ports.
// Revision : 1.0  initial release
// ============================================================================
module otter_mem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int MEM_WORDS  = 16384,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST_N,

  input  logic              dbg_req,
  input  logic              dat_req,
  input  logic              fet_req,
  input  logic              dbg_we,
  input  logic              dat_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [ADDR_W-1:0] dat_addr,
  input  logic [ADDR_W-1:0] fet_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic [31:0]       dat_wdata,
  input  logic [3:0]        dbg_be,
  input  logic [3:0]        dat_be,

  output logic              dbg_gnt,
  output logic              dat_gnt,
  output logic              fet_gnt,
  output logic              dbg_rvalid,
  output logic              dat_rvalid,
  output logic              fet_rvalid,
  output logic [31:0]       rdata,
  output logic              err,

  input  logic              halt_req,
  output logic              halt_ack,

  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [2:0]      c_starve_max = 3'(STARVE_MAX);
  localparam logic [ADDR_W:0] c_mem_words  = (ADDR_W+1)'(MEM_WORDS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_starve;
  logic [2:0]        w_starve_nxt;
  logic              r_rv_dbg;
  logic              r_rv_dat;
  logic              r_rv_fet;
  logic              r_rv_mem;

  logic              w_cpu_ok;
  logic              w_fet_first;
  logic              w_sel_dbg;
  logic              w_sel_dat;
  logic              w_sel_fet;
  logic              w_any;
  logic              w_we;
  logic              w_rd;
  logic              w_oor;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic [3:0]        w_be;

  // Grants are held off while reset is asserted so the outputs read as idle.
  always_comb begin
    w_sel_dbg   = 1'b0;
    w_sel_dat   = 1'b0;
    w_sel_fet   = 1'b0;
    w_cpu_ok    = (r_state == ST_RUN);
    w_fet_first = (r_starve == c_starve_max);
    if (RST_N) begin
      if (dbg_req) begin
        w_sel_dbg = 1'b1;
      end else if (w_cpu_ok) begin
        if (fet_req && (w_fet_first || !dat_req)) begin
          w_sel_fet = 1'b1;
        end else if (dat_req) begin
          w_sel_dat = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    w_be    = 4'b0000;
    if (w_sel_dbg) begin
      w_we    = dbg_we;
      w_addr  = dbg_addr;
      w_wdata = dbg_wdata;
      w_be    = dbg_be;
    end else if (w_sel_dat) begin
      w_we    = dat_we;
      w_addr  = dat_addr;
      w_wdata = dat_wdata;
      w_be    = dat_be;
    end else if (w_sel_fet) begin
      w_addr  = fet_addr;
    end
  end

  assign w_any = w_sel_dbg | w_sel_dat | w_sel_fet;
  assign w_rd  = w_any && !w_we;
  assign w_oor = w_any && ({1'b0, w_addr} >= c_mem_words);

  // Out-of-range accesses are acknowledged but never reach the memory.
  assign mem_en    = w_any && !w_oor;
  assign mem_we    = (mem_en && w_we) ? w_be : 4'b0000;
  assign mem_addr  = w_addr;
  assign mem_wdata = w_we ? w_wdata : 32'd0;
  assign err       = w_oor;

  assign dbg_gnt    = w_sel_dbg;
  assign dat_gnt    = w_sel_dat;
  assign fet_gnt    = w_sel_fet;
  assign dbg_rvalid = r_rv_dbg;
  assign dat_rvalid = r_rv_dat;
  assign fet_rvalid = r_rv_fet;
  assign rdata      = r_rv_mem ? mem_rdata : 32'd0;
  assign halt_ack   = (r_state == ST_HALTED);

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    case (r_state)
      ST_RUN: begin
        if (halt_req) begin
          w_state_nxt = ST_DRAIN;
        end
        w_starve_nxt = (fet_req && !w_sel_fet) ? (r_starve + 3'd1) : 3'd0;
      end
      ST_DRAIN: begin
        // A CPU read granted in the last RUN cycle returns its data here.
        if (!halt_req) begin
          w_state_nxt = ST_RUN;
        end else if (!(r_rv_dat || r_rv_fet)) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (!halt_req) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= ST_RUN;
      r_starve <= 3'd0;
      r_rv_dbg <= 1'b0;
      r_rv_dat <= 1'b0;
      r_rv_fet <= 1'b0;
      r_rv_mem <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_rv_dbg <= w_sel_dbg && !w_we;
      r_rv_dat <= w_sel_dat && !w_we;
      r_rv_fet <= w_sel_fet;
      r_rv_mem <= w_rd && !w_oor;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_otter_mem_arbiter.sv
`default_nettype none
// Bench for otter_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_otter_mem_arbiter;

  localparam int ADDR_W     = 15;
  localparam int MEM_WORDS  = 16384;
  localparam int STARVE_MAX = 4;

  logic              CLK   = 1'b0;
  logic              RST_N = 1'b0;
  logic              dbg_req = 1'b0, dat_req = 1'b0, fet_req = 1'b0;
  logic              dbg_we = 1'b0, dat_we = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = '0, dat_addr = '0, fet_addr = '0;
  logic [31:0]       dbg_wdata = '0, dat_wdata = '0;
  logic [3:0]        dbg_be = '0, dat_be = '0;
  logic              halt_req = 1'b0;
  logic              dbg_gnt, dat_gnt, fet_gnt;
  logic              dbg_rvalid, dat_rvalid, fet_rvalid;
  logic [31:0]       rdata;
  logic              err, halt_ack, mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  otter_mem_arbiter #(
    .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .dbg_req(dbg_req), .dat_req(dat_req), .fet_req(fet_req),
    .dbg_we(dbg_we), .dat_we(dat_we),
    .dbg_addr(dbg_addr), .dat_addr(dat_addr), .fet_addr(fet_addr),
    .dbg_wdata(dbg_wdata), .dat_wdata(dat_wdata),
    .dbg_be(dbg_be), .dat_be(dat_be),
    .dbg_gnt(dbg_gnt), .dat_gnt(dat_gnt), .fet_gnt(fet_gnt),
    .dbg_rvalid(dbg_rvalid), .dat_rvalid(dat_rvalid), .fet_rvalid(fet_rvalid),
    .rdata(rdata), .err(err),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h, required %h", name, act, exp);
  endtask

  // Environment memory: synchronous RAM with one cycle of read latency.
  logic [31:0] env_mem [0:MEM_WORDS-1];
  always @(posedge CLK) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) env_mem[mem_addr[13:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= env_mem[mem_addr[13:0]];
    end
  end

  // Behavioural model. Requesters: 1 = debug, 2 = data, 3 = fetch.
  logic [31:0] ref_mem [0:MEM_WORDS-1];
  int          m_starve = 0;
  bit          m_stop = 0, m_ack = 0;
  int          m_rv_who = 0;
  logic [31:0] m_rv_data = '0;
  bit          m_g_dbg = 0, m_g_dat = 0, m_g_fet = 0;

  int          who;
  int          order [3];
  bit          want, acc_we, oor, exp_en, cpu_rv;
  logic [14:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be, exp_we;

  always @(negedge CLK) begin
    if (!RST_N) begin
      chk("rst_dbg_gnt", 32'(dbg_gnt), 0);
      chk("rst_dat_gnt", 32'(dat_gnt), 0);
      chk("rst_fet_gnt", 32'(fet_gnt), 0);
      chk("rst_dbg_rvalid", 32'(dbg_rvalid), 0);
      chk("rst_dat_rvalid", 32'(dat_rvalid), 0);
      chk("rst_fet_rvalid", 32'(fet_rvalid), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_halt_ack", 32'(halt_ack), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      m_starve = 0; m_stop = 0; m_ack = 0; m_rv_who = 0;
      m_g_dbg = 0; m_g_dat = 0; m_g_fet = 0;
    end else begin
      if (m_starve == STARVE_MAX) order = '{1, 3, 2};
      else                        order = '{1, 2, 3};
      who = 0;
      for (int k = 0; k < 3; k++) begin
        case (order[k])
          1:       want = dbg_req;
          2:       want = dat_req && !m_stop;
          default: want = fet_req && !m_stop;
        endcase
        if (who == 0 && want) who = order[k];
      end
      acc_we = 0; acc_addr = '0; acc_wdata = '0; acc_be = '0;
      case (who)
        1: begin acc_we = dbg_we; acc_addr = dbg_addr; acc_wdata = dbg_wdata; acc_be = dbg_be; end
        2: begin acc_we = dat_we; acc_addr = dat_addr; acc_wdata = dat_wdata; acc_be = dat_be; end
        3: begin acc_addr = fet_addr; end
        default: ;
      endcase
      oor    = (who != 0) && (int'(acc_addr) >= MEM_WORDS);
      exp_en = (who != 0) && !oor;
      exp_we = (exp_en && acc_we) ? acc_be : 4'b0000;

      chk("model_dbg_gnt", 32'(dbg_gnt), 32'(who == 1));
      chk("model_dat_gnt", 32'(dat_gnt), 32'(who == 2));
      chk("model_fet_gnt", 32'(fet_gnt), 32'(who == 3));
      chk("model_err", 32'(err), 32'(oor));
      chk("model_mem_en", 32'(mem_en), 32'(exp_en));
      chk("model_mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_en) chk("model_mem_addr", 32'(mem_addr), 32'(acc_addr));
      if (exp_en && acc_we) chk("model_mem_wdata", mem_wdata, acc_wdata);
      chk("model_dbg_rvalid", 32'(dbg_rvalid), 32'(m_rv_who == 1));
      chk("model_dat_rvalid", 32'(dat_rvalid), 32'(m_rv_who == 2));
      chk("model_fet_rvalid", 32'(fet_rvalid), 32'(m_rv_who == 3));
      if (m_rv_who != 0) chk("model_rdata", rdata, m_rv_data);
      chk("model_halt_ack", 32'(halt_ack), 32'(m_ack));

      cpu_rv = (m_rv_who == 2) || (m_rv_who == 3);
      if (who != 0 && !acc_we) begin
        m_rv_who  = who;
        m_rv_data = oor ? 32'd0 : ref_mem[acc_addr[13:0]];
      end else begin
        m_rv_who = 0;
      end
      if (exp_en && acc_we)
        for (int b = 0; b < 4; b++)
          if (acc_be[b]) ref_mem[acc_addr[13:0]][8*b +: 8] = acc_wdata[8*b +: 8];
      if (!m_stop) m_starve = (fet_req && who != 3) ? (m_starve + 1) % 8 : 0;
      if (!m_stop) begin
        if (halt_req) m_stop = 1;
      end else if (!m_ack) begin
        if (!halt_req) m_stop = 0;
        else if (!cpu_rv) m_ack = 1;
      end else if (!halt_req) begin
        m_stop = 0; m_ack = 0;
      end
      m_g_dbg = (who == 1); m_g_dat = (who == 2); m_g_fet = (who == 3);
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    dbg_req = 0; dat_req = 0; fet_req = 0;
  endtask

  function automatic logic [14:0] rand_addr();
    if ($urandom % 16 == 0) return 15'(MEM_WORDS + $urandom_range(0, MEM_WORDS - 1));
    return 15'($urandom_range(0, 31));
  endfunction

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      env_mem[i] <= 32'd0;
      ref_mem[i] = 32'd0;
    end
    dat_req = 1; fet_req = 1;  // requests during reset must not be granted
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_dat_gnt", 32'(dat_gnt), 0);
    chk("reset_halt_ack", 32'(halt_ack), 0);
    step(); RST_N = 1;

    // Contention: dat,dat,dat,dat,fet repeating
    dat_we = 0; dat_addr = 15'd1; fet_addr = 15'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk($sformatf("contention_fet_gnt_%0d", i), 32'(fet_gnt), 32'(i % 5 == 4));
      chk($sformatf("contention_dat_gnt_%0d", i), 32'(dat_gnt), 32'(i % 5 != 4));
      step();
    end
    idle(); step();

    // Data-port read of 0xDEADBEEF at 0x0010
    dbg_req = 1; dbg_we = 1; dbg_addr = 15'h10; dbg_wdata = 32'hDEADBEEF; dbg_be = 4'hF;
    @(negedge CLK);
    chk("preload_dbg_gnt", 32'(dbg_gnt), 1);
    chk("preload_mem_we", 32'(mem_we), 32'hF);
    step(); dbg_req = 0; dat_req = 1; dat_we = 0; dat_addr = 15'h10;
    @(negedge CLK);
    chk("rd_dat_gnt", 32'(dat_gnt), 1);
    chk("rd_mem_we", 32'(mem_we), 0);
    step(); dat_req = 0;
    @(negedge CLK);
    chk("rd_dat_rvalid", 32'(dat_rvalid), 1);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    chk("rd_fet_rvalid", 32'(fet_rvalid), 0);
    step();

    // Three-way conflict
    dbg_req = 1; dbg_we = 1; dbg_addr = 15'd5; dbg_wdata = 32'h12345678; dbg_be = 4'b0011;
    dat_req = 1; dat_we = 0; dat_addr = 15'd5; fet_req = 1; fet_addr = 15'd3;
    @(negedge CLK);
    chk("conflict_dbg_gnt", 32'(dbg_gnt), 1);
    chk("conflict_mem_we", 32'(mem_we), 32'b0011);
    chk("conflict_mem_wdata", mem_wdata, 32'h12345678);
    chk("conflict_dat_gnt", 32'(dat_gnt), 0);
    chk("conflict_fet_gnt", 32'(fet_gnt), 0);
    step(); dbg_req = 0;
    @(negedge CLK);
    chk("conflict_next_dat_gnt", 32'(dat_gnt), 1);
    step(); dat_req = 0;
    @(negedge CLK);
    chk("conflict_rdata", rdata, 32'h00005678);
    chk("conflict_fet_gnt_late", 32'(fet_gnt), 1);
    step(); idle();

    // Halt during fetch
    fet_req = 1; fet_addr = 15'h10;
    @(negedge CLK);
    chk("halt_fet_gnt", 32'(fet_gnt), 1);
    step(); fet_req = 0; halt_req = 1;
    @(negedge CLK);
    chk("halt_fet_rvalid", 32'(fet_rvalid), 1);
    chk("halt_fet_rdata", rdata, 32'hDEADBEEF);
    chk("halt_ack_c1", 32'(halt_ack), 0);
    step(); dat_req = 1; dat_we = 0; dat_addr = 15'd7; fet_req = 1; fet_addr = 15'd8;
    @(negedge CLK);
    chk("drain_dat_gnt", 32'(dat_gnt), 0);
    chk("drain_fet_gnt", 32'(fet_gnt), 0);
    chk("halt_ack_c2", 32'(halt_ack), 0);
    step();
    @(negedge CLK);
    chk("halt_ack_c3", 32'(halt_ack), 1);
    chk("halted_dat_gnt", 32'(dat_gnt), 0);
    step(); dbg_req = 1; dbg_we = 0; dbg_addr = 15'd5;
    @(negedge CLK);
    chk("halted_dbg_gnt", 32'(dbg_gnt), 1);
    chk("halted_fet_gnt", 32'(fet_gnt), 0);
    step(); dbg_req = 0; halt_req = 0;
    @(negedge CLK);
    chk("halted_dbg_rdata", rdata, 32'h00005678);
    chk("halted_last_ack", 32'(halt_ack), 1);
    chk("halted_last_dat_gnt", 32'(dat_gnt), 0);
    step();
    @(negedge CLK);
    chk("resume_halt_ack", 32'(halt_ack), 0);
    chk("resume_dat_gnt", 32'(dat_gnt), 1);
    step(); idle(); step();

    // Out of range and empty byte-enable write
    fet_req = 1; fet_addr = 15'd16384;
    @(negedge CLK);
    chk("oor_fet_gnt", 32'(fet_gnt), 1);
    chk("oor_err", 32'(err), 1);
    chk("oor_mem_en", 32'(mem_en), 0);
    step(); fet_req = 0; dat_req = 1; dat_we = 1; dat_addr = 15'h7FFF; dat_be = 4'hF; dat_wdata = 32'hA5A5A5A5;
    @(negedge CLK);
    chk("oor_fet_rvalid", 32'(fet_rvalid), 1);
    chk("oor_rdata", rdata, 0);
    chk("oor_wr_err", 32'(err), 1);
    chk("oor_wr_mem_we", 32'(mem_we), 0);
    step(); dat_addr = 15'd9; dat_be = 4'b0000;
    @(negedge CLK);
    chk("be0_dat_gnt", 32'(dat_gnt), 1);
    chk("be0_mem_en", 32'(mem_en), 1);
    chk("be0_mem_we", 32'(mem_we), 0);
    step(); idle();

    // Reset in the cycle after a read grant
    dat_req = 1; dat_we = 0; dat_addr = 15'h10;
    @(negedge CLK);
    chk("rstrd_dat_gnt", 32'(dat_gnt), 1);
    step(); RST_N = 0;
    @(negedge CLK);
    chk("rstrd_dat_rvalid", 32'(dat_rvalid), 0);
    chk("rstrd_dat_gnt_in_rst", 32'(dat_gnt), 0);
    step(); RST_N = 1;
    @(negedge CLK);
    chk("rstrd_first_gnt", 32'(dat_gnt), 1);
    step(); dat_req = 0;
    @(negedge CLK);
    chk("rstrd_rdata", rdata, 32'hDEADBEEF);
    step();

    // Randomized traffic, requesters hold until granted
    for (int c = 0; c < 3000; c++) begin
      if ($urandom % 40 == 0) halt_req = !halt_req;
      if (!dbg_req || m_g_dbg) begin
        dbg_req = ($urandom % 6 == 0); dbg_we = 1'($urandom); dbg_addr = rand_addr();
        dbg_wdata = $urandom; dbg_be = 4'($urandom);
      end
      if (!dat_req || m_g_dat) begin
        dat_req = ($urandom % 2 == 0); dat_we = 1'($urandom); dat_addr = rand_addr();
        dat_wdata = $urandom; dat_be = 4'($urandom);
      end
      if (!fet_req || m_g_fet) begin
        fet_req = ($urandom % 3 != 0); fet_addr = rand_addr();
      end
      step();
    end
    halt_req = 0; idle();
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
